// File: rtl/alu_mdu_pkg.sv
// Shared opcode encodings and FSM state type for the execute-stage ALU/MDU.
package alu_mdu_pkg;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SLTU  = 4'b0011;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_MULT  = 4'b1000;
  localparam logic [3:0] OP_MULTU = 4'b1001;
  localparam logic [3:0] OP_DIV   = 4'b1010;
  localparam logic [3:0] OP_DIVU  = 4'b1011;
  localparam logic [3:0] OP_NOR   = 4'b1100;
  localparam logic [3:0] OP_MFHI  = 4'b1101;
  localparam logic [3:0] OP_MFLO  = 4'b1110;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_e;

  // MULT/MULTU/DIV/DIVU all share the 10xx prefix
  function automatic logic is_mdu_op(input logic [3:0] op);
    return (op[3:2] == 2'b10);
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Radix-2 iterative multiply / restoring divide on operand magnitudes,
// with sign fix-up applied on the way out.
module muldiv_iter
  import alu_mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_div,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             dbz
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);

  logic             busy_q, busy_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hreg_q, hreg_d;
  logic [WIDTH-1:0] lreg_q, lreg_d;
  logic [WIDTH-1:0] breg_q, breg_d;
  logic             div_q, div_d;
  logic             neg_a_q, neg_a_d;
  logic             neg_b_q, neg_b_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     trial, diff, sum;
  logic               ge;
  logic [2*WIDTH-1:0] prod, prod_fix;

  // Operand magnitudes and one shift-add / shift-subtract step
  always_comb begin
    abs_a = (is_signed && a[WIDTH-1]) ? -a : a;
    abs_b = (is_signed && b[WIDTH-1]) ? -b : b;
    trial = {hreg_q, lreg_q[WIDTH-1]};
    diff  = trial - {1'b0, breg_q};
    ge    = (trial >= {1'b0, breg_q});
    sum   = {1'b0, hreg_q} + (lreg_q[0] ? {1'b0, breg_q} : '0);
  end

  // Next-state for counter and shift registers
  always_comb begin
    busy_d  = busy_q;
    cnt_d   = cnt_q;
    hreg_d  = hreg_q;
    lreg_d  = lreg_q;
    breg_d  = breg_q;
    div_d   = div_q;
    neg_a_d = neg_a_q;
    neg_b_d = neg_b_q;
    dbz_d   = dbz_q;
    if (start) begin
      busy_d  = 1'b1;
      cnt_d   = CNT_MAX;
      div_d   = is_div;
      neg_a_d = is_signed & a[WIDTH-1];
      neg_b_d = is_signed & b[WIDTH-1];
      dbz_d   = is_div && (b == '0);
      hreg_d  = '0;
      // div: dividend shifts out of lreg; mul: multiplier shifts out of lreg
      lreg_d  = is_div ? abs_a : abs_b;
      breg_d  = is_div ? abs_b : abs_a;
    end else if (busy_q) begin
      if (div_q) begin
        hreg_d = ge ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
        lreg_d = {lreg_q[WIDTH-2:0], ge};
      end else begin
        hreg_d = sum[WIDTH:1];
        lreg_d = {sum[0], lreg_q[WIDTH-1:1]};
      end
      if (cnt_q == '0) begin
        busy_d = 1'b0;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  // Iteration state registers; reset aborts any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      hreg_q  <= '0;
      lreg_q  <= '0;
      breg_q  <= '0;
      div_q   <= 1'b0;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      hreg_q  <= hreg_d;
      lreg_q  <= lreg_d;
      breg_q  <= breg_d;
      div_q   <= div_d;
      neg_a_q <= neg_a_d;
      neg_b_q <= neg_b_d;
      dbz_q   <= dbz_d;
    end
  end

  // Sign fix-up; a zero divisor forces an all-ones quotient while the
  // remainder naturally ends up equal to the dividend
  always_comb begin
    prod     = {hreg_q, lreg_q};
    prod_fix = (neg_a_q ^ neg_b_q) ? -prod : prod;
    if (div_q) begin
      lo_o = dbz_q ? '1 : ((neg_a_q ^ neg_b_q) ? -lreg_q : lreg_q);
      hi_o = neg_a_q ? -hreg_q : hreg_q;
    end else begin
      lo_o = prod_fix[WIDTH-1:0];
      hi_o = prod_fix[2*WIDTH-1:WIDTH];
    end
    done = busy_q && (cnt_q == '0);
    dbz  = dbz_q;
  end

endmodule

// File: rtl/alu_mdu_seq.sv
// MIPS execute-stage ALU with registered outputs and an iterative MDU that
// owns HI/LO; valid/ready handshake stalls issue while a mul/div runs.
module alu_mdu_seq
  import alu_mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  input  logic [3:0]       ALUop,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_e state_q, state_d;

  logic             accept, mdu_op, mdu_start, wr_back;
  logic             mdu_done, mdu_dbz;
  logic [WIDTH-1:0] mdu_hi, mdu_lo;

  logic [WIDTH-1:0] add_res, sub_res, alu_res;
  logic             slt_bit, sltu_bit;

  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             zero_q, zero_d;
  logic             out_valid_q, out_valid_d;
  logic             dbz_q, dbz_d;

  assign mdu_op = is_mdu_op(ALUop);

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state: RUN lasts until the MDU's final iteration
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept && mdu_op) state_d = ST_RUN;
      ST_RUN:  if (mdu_done) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: handshake, MDU launch and HI/LO writeback strobe
  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    accept    = in_valid && in_ready;
    mdu_start = accept && mdu_op;
    wr_back   = (state_q == ST_DONE);
  end

  muldiv_iter #(.WIDTH(WIDTH)) u_mdu (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (mdu_start),
    .is_div    ((ALUop == OP_DIV) || (ALUop == OP_DIVU)),
    .is_signed ((ALUop == OP_MULT) || (ALUop == OP_DIV)),
    .a         (opA),
    .b         (opB),
    .done      (mdu_done),
    .hi_o      (mdu_hi),
    .lo_o      (mdu_lo),
    .dbz       (mdu_dbz)
  );

  // Single-cycle datapath; SLT picks A's sign when signs differ, so the
  // subtraction overflow case is handled without a separate flag
  always_comb begin
    add_res  = opA + opB;
    sub_res  = opA - opB;
    slt_bit  = (opA[WIDTH-1] != opB[WIDTH-1]) ? opA[WIDTH-1] : sub_res[WIDTH-1];
    sltu_bit = (opA < opB);
    alu_res  = '0;
    case (ALUop)
      OP_AND:  alu_res = opA & opB;
      OP_OR:   alu_res = opA | opB;
      OP_ADD:  alu_res = add_res;
      OP_SUB:  alu_res = sub_res;
      OP_SLT:  alu_res[0] = slt_bit;
      OP_SLTU: alu_res[0] = sltu_bit;
      OP_NOR:  alu_res = ~(opA | opB);
      OP_MFHI: alu_res = hi_q;
      OP_MFLO: alu_res = lo_q;
      default: alu_res = '0;
    endcase
  end

  // Result / HI / LO next-state: MDU writeback or single-cycle result
  always_comb begin
    result_d    = result_q;
    zero_d      = zero_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    out_valid_d = 1'b0;
    dbz_d       = 1'b0;
    if (wr_back) begin
      hi_d        = mdu_hi;
      lo_d        = mdu_lo;
      result_d    = mdu_lo;
      zero_d      = (mdu_lo == '0);
      out_valid_d = 1'b1;
      dbz_d       = mdu_dbz;
    end else if (accept && !mdu_op) begin
      result_d    = alu_res;
      zero_d      = (alu_res == '0);
      out_valid_d = 1'b1;
    end
  end

  // Output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q    <= '0;
      zero_q      <= 1'b1;
      hi_q        <= '0;
      lo_q        <= '0;
      out_valid_q <= 1'b0;
      dbz_q       <= 1'b0;
    end else begin
      result_q    <= result_d;
      zero_q      <= zero_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      out_valid_q <= out_valid_d;
      dbz_q       <= dbz_d;
    end
  end

  assign result      = result_q;
  assign zero        = zero_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign out_valid   = out_valid_q;
  assign div_by_zero = dbz_q;

endmodule
